// File: rtl/gpu_pkg.sv
// Shared GPU encodings: core FSM states, write-back source select and
// register file layout, used by the decoder, core FSM and register file.
package gpu_pkg;

  localparam int NUM_REGS = 16;

  // R13-R15 are read-only special registers
  localparam logic [3:0] FIRST_RO_REG  = 4'd13;
  localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
  localparam logic [3:0] REG_THREAD_ID = 4'd15;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  localparam logic [1:0] RF_SRC_ALU   = 2'b00;
  localparam logic [1:0] RF_SRC_MEM   = 2'b01;
  localparam logic [1:0] RF_SRC_CONST = 2'b10;

endpackage

// File: rtl/register_file.sv
// Per-thread register file: 13 general registers plus read-only block id,
// block dimension and thread id; operands latched in REQUEST, results written in UPDATE.
module register_file
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  logic [DATA_BITS-1:0] regs [NUM_REGS];
  logic [DATA_BITS-1:0] write_data;
  logic                 write_valid;

  // The reserved source encoding and any read-only destination suppress the write
  always_comb begin
    write_data  = '0;
    write_valid = 1'b0;
    if (core_state == S_UPDATE && decoded_reg_write_enable &&
        decoded_rd_address < FIRST_RO_REG) begin
      case (decoded_reg_input_mux)
        RF_SRC_ALU: begin
          write_data  = alu_out;
          write_valid = 1'b1;
        end
        RF_SRC_MEM: begin
          write_data  = lsu_out;
          write_valid = 1'b1;
        end
        RF_SRC_CONST: begin
          write_data  = decoded_immediate;
          write_valid = 1'b1;
        end
        default: begin
          write_data  = '0;
          write_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[REG_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
      regs[REG_THREAD_ID] <= DATA_BITS'(THREAD_ID);
      rs <= '0;
      rt <= '0;
    end else if (enable) begin
      // Operand reads see pre-edge contents, so R13 lags block_id by one cycle
      regs[REG_BLOCK_ID] <= block_id;
      if (core_state == S_REQUEST) begin
        rs <= regs[decoded_rs_address];
        rt <= regs[decoded_rt_address];
      end
      if (write_valid) begin
        regs[decoded_rd_address] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a reference register model pushes expected
// rs/rt each cycle into a scoreboard that is popped after every clock edge.
module tb_register_file;
  import gpu_pkg::*;

  localparam int TPB = 4;
  localparam int TID = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rd_addr;
  logic [3:0] rs_addr;
  logic [3:0] rt_addr;
  logic       reg_we;
  logic [1:0] reg_mux;
  logic [7:0] immediate;
  logic [7:0] alu_out;
  logic [7:0] lsu_out;
  logic [7:0] rs;
  logic [7:0] rt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_regs [16];
  logic [7:0]  model_rs;
  logic [7:0]  model_rt;
  logic [15:0] scoreboard [$];

  always #5 clk = ~clk;

  register_file #(
    .THREADS_PER_BLOCK(TPB),
    .THREAD_ID        (TID),
    .DATA_BITS        (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .block_id                (block_id),
    .core_state              (core_state),
    .decoded_rd_address      (rd_addr),
    .decoded_rs_address      (rs_addr),
    .decoded_rt_address      (rt_addr),
    .decoded_reg_write_enable(reg_we),
    .decoded_reg_input_mux   (reg_mux),
    .decoded_immediate       (immediate),
    .alu_out                 (alu_out),
    .lsu_out                 (lsu_out),
    .rs                      (rs),
    .rt                      (rt)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance the reference model from the current inputs, clock the DUT, then score
  task automatic tick();
    logic [7:0]  old_regs [16];
    logic [15:0] expected;
    old_regs = model_regs;
    if (reset) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
      model_regs[14] = 8'(TPB);
      model_regs[15] = 8'(TID);
      model_rs = 8'h00;
      model_rt = 8'h00;
    end else if (enable) begin
      model_regs[13] = block_id;
      if (core_state == S_REQUEST) begin
        model_rs = old_regs[rs_addr];
        model_rt = old_regs[rt_addr];
      end
      if (core_state == S_UPDATE && reg_we && rd_addr <= 4'd12) begin
        if (reg_mux == 2'b00) model_regs[rd_addr] = alu_out;
        if (reg_mux == 2'b01) model_regs[rd_addr] = lsu_out;
        if (reg_mux == 2'b10) model_regs[rd_addr] = immediate;
      end
    end
    scoreboard.push_back({model_rs, model_rt});
    @(posedge clk);
    #1;
    total++;
    assert (scoreboard.size() > 0)
    else begin
      bad++;
      $error("[TB] FAIL sb_empty observed=%0d expected=1", scoreboard.size());
    end
    if (scoreboard.size() > 0) begin
      expected = scoreboard.pop_front();
      checkOutput("sb_rs", rs, expected[15:8]);
      checkOutput("sb_rt", rt, expected[7:0]);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic [3:0] rd_i,
                               input logic [3:0] rs_i, input logic [3:0] rt_i,
                               input logic we_i, input logic [1:0] mux_i,
                               input logic [7:0] imm_i, input logic [7:0] alu_i,
                               input logic [7:0] lsu_i);
    core_state = st;
    rd_addr    = rd_i;
    rs_addr    = rs_i;
    rt_addr    = rt_i;
    reg_we     = we_i;
    reg_mux    = mux_i;
    immediate  = imm_i;
    alu_out    = alu_i;
    lsu_out    = lsu_i;
    tick();
  endtask

  // REQUEST then one WAIT cycle, so held operands are also scored
  task automatic request(input logic [3:0] rs_i, input logic [3:0] rt_i);
    applyStimulus(S_REQUEST, 4'd0, rs_i, rt_i, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    applyStimulus(S_WAIT, 4'd0, rs_i, rt_i, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic writeReg(input logic [3:0] rd_i, input logic [1:0] mux_i,
                          input logic [7:0] imm_i, input logic [7:0] alu_i,
                          input logic [7:0] lsu_i);
    applyStimulus(S_UPDATE, rd_i, 4'd0, 4'd0, 1'b1, mux_i, imm_i, alu_i, lsu_i);
    applyStimulus(S_DONE, rd_i, 4'd0, 4'd0, 1'b0, mux_i, imm_i, alu_i, lsu_i);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    block_id   = 8'h00;
    core_state = S_IDLE;
    rd_addr    = 4'd0;
    rs_addr    = 4'd0;
    rt_addr    = 4'd0;
    reg_we     = 1'b0;
    reg_mux    = 2'b00;
    immediate  = 8'h00;
    alu_out    = 8'h00;
    lsu_out    = 8'h00;
    model_rs   = 8'h00;
    model_rt   = 8'h00;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    $display("[TB] start");

    // Reset state and special registers
    tick();
    checkOutput("reset_rs", rs, 8'h00);
    checkOutput("reset_rt", rt, 8'h00);
    reset = 1'b0;
    request(4'd14, 4'd15);
    checkOutput("r14_dim", rs, 8'd4);
    checkOutput("r15_tid", rt, 8'd2);
    for (int i = 0; i < 13; i += 2) begin
      request(4'(i), 4'(i + 1 > 12 ? 12 : i + 1));
      checkOutput("gp_zero_rs", rs, 8'h00);
      checkOutput("gp_zero_rt", rt, 8'h00);
    end

    // Constant write, then reserved source must not write
    writeReg(4'd3, RF_SRC_CONST, 8'h2A, 8'h00, 8'h00);
    writeReg(4'd3, 2'b11, 8'h99, 8'h55, 8'h66);
    request(4'd3, 4'd3);
    checkOutput("r3_const_rs", rs, 8'h2A);
    checkOutput("r3_const_rt", rt, 8'h2A);

    // ALU and memory write-back
    writeReg(4'd5, RF_SRC_ALU, 8'h00, 8'h07, 8'h00);
    writeReg(4'd6, RF_SRC_MEM, 8'h00, 8'h00, 8'hC3);
    request(4'd5, 4'd6);
    checkOutput("r5_alu", rs, 8'h07);
    checkOutput("r6_mem", rt, 8'hC3);

    // Read-only registers ignore writes; R13 follows block_id
    block_id = 8'd9;
    writeReg(4'd13, RF_SRC_CONST, 8'hFF, 8'hFF, 8'hFF);
    writeReg(4'd14, RF_SRC_ALU, 8'hFF, 8'hFF, 8'hFF);
    writeReg(4'd15, RF_SRC_MEM, 8'hFF, 8'hFF, 8'hFF);
    request(4'd13, 4'd14);
    checkOutput("r13_bid", rs, 8'd9);
    checkOutput("r14_ro", rt, 8'd4);
    request(4'd15, 4'd15);
    checkOutput("r15_ro", rs, 8'd2);

    // enable low freezes everything
    writeReg(4'd1, RF_SRC_CONST, 8'h5A, 8'h00, 8'h00);
    request(4'd0, 4'd0);
    enable   = 1'b0;
    block_id = 8'd3;
    writeReg(4'd1, RF_SRC_CONST, 8'h77, 8'h00, 8'h00);
    request(4'd1, 4'd13);
    checkOutput("frozen_rs", rs, 8'h00);
    checkOutput("frozen_rt", rt, 8'h00);
    enable = 1'b1;
    request(4'd1, 4'd13);
    checkOutput("r1_kept", rs, 8'h5A);
    checkOutput("r13_kept", rt, 8'd9);
    request(4'd13, 4'd13);
    checkOutput("r13_refresh", rs, 8'd3);

    // Reset during UPDATE discards the pending write
    writeReg(4'd2, RF_SRC_CONST, 8'h44, 8'h00, 8'h00);
    request(4'd2, 4'd3);
    checkOutput("r2_pre", rs, 8'h44);
    checkOutput("r3_pre", rt, 8'h2A);
    reset = 1'b1;
    applyStimulus(S_UPDATE, 4'd2, 4'd2, 4'd2, 1'b1, RF_SRC_CONST, 8'h11, 8'h00, 8'h00);
    checkOutput("rst_rs", rs, 8'h00);
    checkOutput("rst_rt", rt, 8'h00);
    reset = 1'b0;
    request(4'd2, 4'd13);
    checkOutput("r2_cleared", rs, 8'h00);
    checkOutput("r13_cleared", rt, 8'h00);
    request(4'd14, 4'd15);
    checkOutput("r14_after", rs, 8'd4);
    checkOutput("r15_after", rt, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
